// File: rtl/serial_rx_framer.sv
// serial_rx_framer: hunts the line for a start pattern, shifts in a payload MSB-first
// with optional even parity, and offers it through a ready/valid holding register.
module serial_rx_framer #(
    parameter int                   DATA_W    = 55,
    parameter int                   START_LEN = 2,
    parameter logic [START_LEN-1:0] START_PAT = 2'b01,
    parameter bit                   PARITY_EN = 1'b0
) (
    input  logic              Clk_S,
    input  logic              Rst_n,
    input  logic              S_Data,
    input  logic              RX_Ready,
    output logic [DATA_W-1:0] RX_Data,
    output logic              RX_Data_Valid,
    output logic              Frame_Err,
    output logic              Overrun,
    output logic              Busy
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {HUNT, DATA, PAR} state_t;

    state_t                 state, state_n;
    logic [START_LEN-1:0]   hunt, hunt_n;
    logic [DATA_W-1:0]      sh, sh_n, word;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   last, good, bad, load;

    always_comb begin
        state_n = state;
        hunt_n  = hunt;
        sh_n    = sh;
        cnt_n   = cnt;
        word    = sh;
        good    = 1'b0;
        bad     = 1'b0;
        last    = cnt == CW'(DATA_W - 1);
        case (state)
            HUNT: begin
                hunt_n = START_LEN'({hunt, S_Data});
                if (hunt_n == START_PAT) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end
            end
            DATA: begin
                sh_n  = {sh[DATA_W-2:0], S_Data};
                cnt_n = cnt + 1'b1;
                word  = sh_n;
                if (last) begin
                    state_n = PARITY_EN ? PAR : HUNT;
                    hunt_n  = PARITY_EN ? hunt : ~START_PAT;
                    good    = !PARITY_EN;
                end
            end
            PAR: begin
                state_n = HUNT;
                hunt_n  = ~START_PAT;
                bad     = ^{sh, S_Data};
                good    = ~bad;
            end
            default: state_n = HUNT;
        endcase
        // a good frame only lands if the holding register is free or emptying now
        load = good & (~RX_Data_Valid | RX_Ready);
    end

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= HUNT;
            hunt          <= ~START_PAT;
            sh            <= '0;
            cnt           <= '0;
            RX_Data       <= '0;
            RX_Data_Valid <= 1'b0;
            Frame_Err     <= 1'b0;
            Overrun       <= 1'b0;
        end else begin
            state         <= state_n;
            hunt          <= hunt_n;
            sh            <= sh_n;
            cnt           <= cnt_n;
            RX_Data       <= load ? word : RX_Data;
            RX_Data_Valid <= load | (RX_Data_Valid & ~RX_Ready);
            Frame_Err     <= bad;
            Overrun       <= good & RX_Data_Valid & ~RX_Ready;
        end
    end

    assign Busy = state != HUNT;
endmodule

// File: tb/tb_serial_rx_framer.sv
// tb_serial_rx_framer: directed and randomized frames on a 55-bit plain receiver
// and an 8-bit even-parity receiver, checked against a frame-level model.
module tb_serial_rx_framer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s0 = 1'b0, r0 = 1'b0, s1 = 1'b0, r1 = 1'b0;
    logic [54:0] d0;
    logic [7:0]  d1;
    logic        v0, fe0, ov0, b0, v1, fe1, ov1, b1;

    int          tests = 0;
    int          fails = 0;
    bit          ev [2];
    logic [63:0] ed [2];

    always #5 clk = ~clk;

    serial_rx_framer u0 (
        .Clk_S(clk), .Rst_n(rst_n), .S_Data(s0), .RX_Ready(r0), .RX_Data(d0),
        .RX_Data_Valid(v0), .Frame_Err(fe0), .Overrun(ov0), .Busy(b0)
    );

    serial_rx_framer #(.DATA_W(8), .PARITY_EN(1'b1)) u1 (
        .Clk_S(clk), .Rst_n(rst_n), .S_Data(s1), .RX_Ready(r1), .RX_Data(d1),
        .RX_Data_Valid(v1), .Frame_Err(fe1), .Overrun(ov1), .Busy(b1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input int d, input bit fe, input bit ov, input bit bsy);
        chk("d0_data",  64'(d0), ed[0]);
        chk("d0_valid", 64'(v0), 64'(ev[0]));
        chk("d0_ferr",  64'(fe0), 64'(d == 0 && fe));
        chk("d0_ovr",   64'(ov0), 64'(d == 0 && ov));
        chk("d0_busy",  64'(b0), 64'(d == 0 && bsy));
        chk("d1_data",  64'(d1), ed[1]);
        chk("d1_valid", 64'(v1), 64'(ev[1]));
        chk("d1_ferr",  64'(fe1), 64'(d == 1 && fe));
        chk("d1_ovr",   64'(ov1), 64'(d == 1 && ov));
        chk("d1_busy",  64'(b1), 64'(d == 1 && bsy));
    endtask

    function automatic bit rd(input int m);
        return (m == 2) ? bit'($urandom_range(0, 1)) : bit'(m);
    endfunction

    // one line bit on receiver d; fin/ok describe whether this bit ends a frame and how
    task automatic step(input int d, input bit b, input bit rdy, input bit fin, input bit ok,
                        input logic [63:0] w, input bit bsy);
        bit fe, ov;
        if (d == 0) begin s0 = b; r0 = rdy; s1 = 1'b0; r1 = 1'b0; end
        else        begin s1 = b; r1 = rdy; s0 = 1'b0; r0 = 1'b0; end
        @(posedge clk);
        fe = fin && !ok;
        ov = fin && ok && ev[d] && !rdy;
        if (fin && ok && (!ev[d] || rdy)) begin
            ev[d] = 1'b1;
            ed[d] = w;
        end else if (ev[d] && rdy) ev[d] = 1'b0;
        #1;
        chk_all(d, fe, ov, bsy);
    endtask

    task automatic idle(input int d, input int n, input int rmode);
        for (int i = 0; i < n; i++) step(d, 1'b0, rd(rmode), 1'b0, 1'b1, 64'd0, 1'b0);
    endtask

    task automatic send_frame(input int d, input logic [63:0] w, input bit flip,
                              input int rmode, input bit fin_rdy);
        int          wd = (d == 1) ? 8 : 55;
        bit          pe = (d == 1);
        logic [63:0] wm = w & ((64'd1 << wd) - 64'd1);
        bit          par = (^wm) ^ flip;
        bit          lst;
        step(d, 1'b0, rd(rmode), 1'b0, 1'b1, 64'd0, 1'b0);
        step(d, 1'b1, rd(rmode), 1'b0, 1'b1, 64'd0, 1'b1);
        for (int i = wd - 1; i >= 0; i--) begin
            lst = (i == 0) && !pe;
            step(d, wm[i], lst ? fin_rdy : rd(rmode), lst, 1'b1, wm, !lst);
        end
        if (pe) step(d, par, fin_rdy, 1'b1, !flip, wm, 1'b0);
    endtask

    initial begin
        ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = '0; ed[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        idle(0, 3, 2);
        // plain receiver: load, drain, load with ready low, overrun on a full register
        send_frame(0, 64'h5A_A5A5_A5A5_A5A5, 1'b0, 0, 1'b0);
        idle(0, 1, 1);
        send_frame(0, 64'h0, 1'b0, 0, 1'b0);
        idle(0, 2, 1);
        send_frame(0, 64'h5A_A5A5_A5A5_A5A5, 1'b0, 0, 1'b0);
        send_frame(0, 64'h1, 1'b0, 0, 1'b0);
        idle(0, 2, 1);
        // parity receiver: good frame, bad parity, completion coinciding with a transfer
        send_frame(1, 64'hA5, 1'b0, 0, 1'b0);
        idle(1, 1, 1);
        send_frame(1, 64'hA5, 1'b1, 0, 1'b0);
        send_frame(1, 64'h3C, 1'b0, 0, 1'b0);
        send_frame(1, 64'hA5, 1'b1, 0, 1'b0);
        send_frame(1, 64'hC3, 1'b0, 0, 1'b1);
        idle(1, 2, 0);
        // reset in the middle of a payload with a word still held
        step(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1);
        for (int i = 0; i < 21; i++) step(0, 1'(i % 3 == 0), 1'b0, 1'b0, 1'b1, 64'd0, 1'b1);
        s0 = 1'b0;
        #2 rst_n = 1'b0;
        ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = '0; ed[1] = '0;
        #1;
        chk_all(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        send_frame(0, 64'h7, 1'b0, 0, 1'b0);
        idle(0, 1, 1);
        // randomized frames, gaps and ready behaviour on both receivers
        for (int n = 0; n < 40; n++) begin
            int d = n % 2;
            send_frame(d, {$urandom, $urandom}, bit'($urandom_range(0, 3) == 0),
                       2, bit'($urandom_range(0, 1)));
            idle(d, $urandom_range(0, 3), 2);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
